axis_video_source: RTL and testbench
====================================

AXIS_VIDEO_SOURCE -- requirements
Module: axis_video_source

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter FRAME_WIDTH, default 640, pixels per line.
REQ-003 SHALL have parameter FRAME_HEIGHT, default 512, lines per frame.
REQ-004 SHALL have parameter LINE_GAP, default 0, idle cycles inserted after each non-final line.
REQ-005 SHALL have parameter FRAME_GAP, default 0, idle cycles inserted after each frame.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port start  input  1  request to begin generation, sampled in IDLE.
REQ-009 SHALL have port continuous  input  1  when 1, frames repeat until stop.
REQ-010 SHALL have port stop  input  1  request to end generation at the next frame boundary.
REQ-011 SHALL have port pattern_sel  input  2  test pattern select.
REQ-012 SHALL have port const_value  input  DATA_WIDTH  pixel value for the constant pattern.
REQ-013 SHALL have port m_axis_tdata  output  DATA_WIDTH  pixel.
REQ-014 SHALL have port m_axis_tvalid  output  1  beat valid.
REQ-015 SHALL have port m_axis_tlast  output  1  last pixel of a line.
REQ-016 SHALL have port m_axis_tuser  output  1  first pixel of a frame.
REQ-017 SHALL have port m_axis_tready  input  1  sink ready.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.
REQ-019 SHALL have port frame_done  output  1  one-cycle pulse after the last beat of a frame is accepted.

Function
REQ-020 SHALL implement the states IDLE, ACTIVE, LINE_GAP, FRAME_GAP.
REQ-021 SHALL move IDLE->ACTIVE on start=1 and, in the same cycle, latch pattern_sel and const_value; the latched values hold for the whole frame.
REQ-022 SHALL count hcnt 0..FRAME_WIDTH-1 and vcnt 0..FRAME_HEIGHT-1, advancing only on fire (m_axis_tvalid && m_axis_tready).
REQ-023 SHALL assert m_axis_tvalid only in ACTIVE, with data, tlast and tuser registered (no combinational path from m_axis_tready).
REQ-024 SHALL hold tdata, tlast and tuser stable and keep tvalid high while tvalid=1 and tready=0.
REQ-025 SHALL set m_axis_tuser=1 only for the beat at hcnt=0, vcnt=0.
REQ-026 SHALL set m_axis_tlast=1 only for the beat at hcnt=FRAME_WIDTH-1.
REQ-027 SHALL generate pixels per pattern_sel: 0 = hcnt[DATA_WIDTH-1:0]; 1 = vcnt[DATA_WIDTH-1:0]; 2 = all-ones if hcnt[3]^vcnt[3] else 0; 3 = latched const_value; counters are truncated (wrap) when wider than DATA_WIDTH.
REQ-028 On fire with tlast and vcnt<FRAME_HEIGHT-1, SHALL reset hcnt to 0, increment vcnt, and enter LINE_GAP for LINE_GAP cycles, or stay in ACTIVE with no bubble if LINE_GAP=0.
REQ-029 On fire of the final beat, SHALL clear both counters, pulse frame_done in the next cycle, and enter FRAME_GAP for FRAME_GAP cycles (zero cycles if FRAME_GAP=0).
REQ-030 At the end of a frame, SHALL re-latch the inputs and return to ACTIVE if continuous=1 and no stop is pending; otherwise it SHALL go to IDLE.
REQ-031 SHALL register a stop pulse arriving at any time while busy as pending, SHALL honor it only at the frame boundary (never truncating a frame), and SHALL clear it on entering IDLE.
REQ-032 SHALL ignore start while busy.
REQ-033 SHALL accept simultaneous start and stop in IDLE as start, generating exactly one frame.
REQ-034 SHALL size the gap counters by $clog2 of each gap value plus 1.

Reset
REQ-035 While rst_n=0, SHALL hold state=IDLE, hcnt=0, vcnt=0, m_axis_tvalid=0, tlast=0, tuser=0, tdata=0, busy=0, frame_done=0, and stop pending cleared.
REQ-036 SHALL force these values immediately on rst_n assertion, including mid-frame; generation resumes only on a new start after release.

Verification
REQ-037 SHALL cover: FRAME_WIDTH=4, FRAME_HEIGHT=2, pattern 0, tready=1, start pulse -> 8 consecutive beats with data 0,1,2,3,0,1,2,3; tuser on beat 0; tlast on beats 3 and 7; frame_done 1 cycle after beat 7; busy then 0.
REQ-038 SHALL cover: same setup, tready toggled randomly -> identical beat sequence, with outputs stable during every stall.
REQ-039 SHALL cover: LINE_GAP=2, FRAME_GAP=3, continuous=1 -> exactly 2 tvalid=0 cycles between beat 3 and beat 4, 3 idle cycles between frames, and tuser on the first beat of frame 2.
REQ-040 SHALL cover: continuous=1 with stop pulsed at beat 5 -> frame completes all 8 beats, then IDLE with no further tvalid.
REQ-041 SHALL cover: pattern 3, const_value=0xA5, const_value changed to 0x00 mid-frame -> all 8 beats equal 0xA5.
REQ-042 SHALL cover: rst_n asserted with tvalid=1 at beat 2 -> tvalid=0 at once and busy=0; a new start then yields tuser on a beat with data 0.

Source files
------------

// File: rtl/axis_video_if.sv
// AXI4-Stream video beat bundle: pixel data plus line/frame markers and handshake.
interface axis_video_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_video_source.sv
// Test-pattern video frame generator on AXI4-Stream; first beat one cycle after start.
// All beat outputs registered; a stalled beat holds until m_axis.tready accepts it.
module axis_video_source #(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 512,
  parameter int LINE_GAP     = 0,
  parameter int FRAME_GAP    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  stop,
  input  logic [1:0]            pattern_sel,
  input  logic [DATA_WIDTH-1:0] const_value,
  axis_video_if.master          m_axis,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int HW  = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int VW  = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int LGW = $clog2(LINE_GAP) + 1;
  localparam int FGW = $clog2(FRAME_GAP) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_LINE_GAP, S_FRAME_GAP} state_t;

  state_t                state, state_nxt;
  logic [HW-1:0]         hcnt, hcnt_nxt;
  logic [VW-1:0]         vcnt, vcnt_nxt;
  logic [LGW-1:0]        lg_cnt;
  logic [FGW-1:0]        fg_cnt;
  logic [1:0]            pat_q, pat_use;
  logic [DATA_WIDTH-1:0] cval_q, cval_use;
  logic                  stop_pend;
  logic                  tvalid_q, tlast_q, tuser_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  fire, line_end, frame_end, keep_going, relatch, load_beat;

  function automatic logic [DATA_WIDTH-1:0] pixel(input logic [1:0] pat,
                                                   input logic [DATA_WIDTH-1:0] cval,
                                                   input logic [HW-1:0] h,
                                                   input logic [VW-1:0] v);
    case (pat)
      2'd0:    pixel = DATA_WIDTH'(h);
      2'd1:    pixel = DATA_WIDTH'(v);
      2'd2:    pixel = {DATA_WIDTH{1'(h >> 3) ^ 1'(v >> 3)}};
      default: pixel = cval;
    endcase
  endfunction

  assign fire       = tvalid_q && m_axis.tready;
  assign line_end   = (hcnt == HW'(FRAME_WIDTH - 1));
  assign frame_end  = fire && line_end && (vcnt == VW'(FRAME_HEIGHT - 1));
  // A stop seen in the same cycle as the frame boundary still counts as pending.
  assign keep_going = continuous && !(stop_pend || stop);

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    vcnt_nxt  = vcnt;
    relatch   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_ACTIVE;
          relatch   = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (fire) begin
          if (!line_end) begin
            hcnt_nxt = hcnt + 1'b1;
          end else begin
            hcnt_nxt = '0;
            if (frame_end) begin
              vcnt_nxt = '0;
              if (FRAME_GAP > 0) begin
                state_nxt = S_FRAME_GAP;
              end else if (keep_going) begin
                relatch = 1'b1;
              end else begin
                state_nxt = S_IDLE;
              end
            end else begin
              vcnt_nxt = vcnt + 1'b1;
              if (LINE_GAP > 0) state_nxt = S_LINE_GAP;
            end
          end
        end
      end
      S_LINE_GAP: begin
        if (lg_cnt == '0) state_nxt = S_ACTIVE;
      end
      S_FRAME_GAP: begin
        if (fg_cnt == '0) begin
          if (keep_going) begin
            state_nxt = S_ACTIVE;
            relatch   = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The beat register is reloaded when entering ACTIVE or after an accepted beat.
  assign load_beat = (state_nxt == S_ACTIVE) && ((state != S_ACTIVE) || fire);
  assign pat_use   = relatch ? pattern_sel : pat_q;
  assign cval_use  = relatch ? const_value : cval_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      hcnt       <= '0;
      vcnt       <= '0;
      lg_cnt     <= '0;
      fg_cnt     <= '0;
      pat_q      <= '0;
      cval_q     <= '0;
      stop_pend  <= 1'b0;
      frame_done <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      tdata_q    <= '0;
    end else begin
      state      <= state_nxt;
      hcnt       <= hcnt_nxt;
      vcnt       <= vcnt_nxt;
      stop_pend  <= (state_nxt == S_IDLE) ? 1'b0 : (stop_pend | stop);
      frame_done <= frame_end;
      if (relatch) begin
        pat_q  <= pattern_sel;
        cval_q <= const_value;
      end
      if (state_nxt == S_LINE_GAP && state != S_LINE_GAP) lg_cnt <= LGW'(LINE_GAP - 1);
      else if (state == S_LINE_GAP)                      lg_cnt <= lg_cnt - 1'b1;
      if (state_nxt == S_FRAME_GAP && state != S_FRAME_GAP) fg_cnt <= FGW'(FRAME_GAP - 1);
      else if (state == S_FRAME_GAP)                       fg_cnt <= fg_cnt - 1'b1;
      if (load_beat) begin
        tvalid_q <= 1'b1;
        tdata_q  <= pixel(pat_use, cval_use, hcnt_nxt, vcnt_nxt);
        tlast_q  <= (hcnt_nxt == HW'(FRAME_WIDTH - 1));
        tuser_q  <= (hcnt_nxt == '0) && (vcnt_nxt == '0);
      end else if (state_nxt != S_ACTIVE) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
        tuser_q  <= 1'b0;
      end
    end
  end

  assign busy          = (state != S_IDLE);
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;
endmodule

// File: tb/tb_axis_video_source.sv
// Bench for axis_video_source: a no-gap instance and a gapped instance on a 4x2 frame.
module tb_axis_video_source;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start0 = 1'b0, start1 = 1'b0;
  logic          continuous = 1'b0, stop = 1'b0;
  logic [1:0]    pattern_sel = '0;
  logic [DW-1:0] const_value = '0;
  logic          busy0, fd0, busy1, fd1;
  bit            rnd0 = 1'b0;

  axis_video_if #(.DATA_WIDTH(DW)) if0 ();
  axis_video_if #(.DATA_WIDTH(DW)) if1 ();

  axis_video_source #(.DATA_WIDTH(DW), .FRAME_WIDTH(W), .FRAME_HEIGHT(H),
                      .LINE_GAP(0), .FRAME_GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .continuous(continuous), .stop(stop),
    .pattern_sel(pattern_sel), .const_value(const_value), .m_axis(if0),
    .busy(busy0), .frame_done(fd0));

  axis_video_source #(.DATA_WIDTH(DW), .FRAME_WIDTH(W), .FRAME_HEIGHT(H),
                      .LINE_GAP(2), .FRAME_GAP(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .continuous(continuous), .stop(stop),
    .pattern_sel(pattern_sel), .const_value(const_value), .m_axis(if1),
    .busy(busy1), .frame_done(fd1));

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
    int            cyc;
  } beat_t;

  int    cyc = 0;
  int    n_tests = 0, n_fail = 0;
  beat_t q0[$], q1[$];
  int    fdq0[$];
  logic  fdb0[$];
  int    vld0 = 0;
  logic  st0 = 1'b0;
  logic [DW+1:0] sbeat0 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference pixel rule, stated arithmetically.
  function automatic logic [DW-1:0] exp_pix(input int pat, input int cv, input int h, input int v);
    case (pat)
      0:       return DW'(h % 256);
      1:       return DW'(v % 256);
      2:       return (((h / 8) % 2) != ((v / 8) % 2)) ? 8'hFF : 8'h00;
      default: return DW'(cv);
    endcase
  endfunction

  // Monitors sample on the falling edge; a beat seen with tvalid&&tready fires on the next rise.
  always @(negedge clk) begin
    if (!rst_n) begin
      st0 <= 1'b0;
    end else begin
      if (st0) begin
        check_eq("stall_vld", 32'(if0.tvalid), 32'd1);
        check_eq("stall_beat", 32'({if0.tdata, if0.tlast, if0.tuser}), 32'(sbeat0));
      end
      if (if0.tvalid) vld0 <= vld0 + 1;
      if (if0.tvalid && if0.tready)
        q0.push_back('{data: if0.tdata, last: if0.tlast, user: if0.tuser, cyc: cyc});
      if (fd0) begin
        fdq0.push_back(cyc);
        fdb0.push_back(busy0);
      end
      st0    <= if0.tvalid && !if0.tready;
      sbeat0 <= {if0.tdata, if0.tlast, if0.tuser};
    end
  end

  always @(negedge clk) begin
    if (rst_n && if1.tvalid && if1.tready)
      q1.push_back('{data: if1.tdata, last: if1.tlast, user: if1.tuser, cyc: cyc});
  end

  initial begin
    if0.tready = 1'b1;
    if1.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if0.tready = rnd0 ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int which);
    @(posedge clk);
    #1;
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  task automatic wait_idle(input int which, input int lim, input string tag);
    int i = 0;
    while (((which == 0) ? busy0 : busy1) && i < lim) begin
      tick(1);
      i++;
    end
    check_eq({tag, "_idle"}, 32'((which == 0) ? busy0 : busy1), 32'd0);
  endtask

  task automatic wait_beats(input int which, input int n, input int lim, input string tag);
    int i = 0;
    while (((which == 0) ? q0.size() : q1.size()) < n && i < lim) begin
      tick(1);
      i++;
    end
    check_eq({tag, "_beats"}, 32'(((which == 0) ? q0.size() : q1.size()) >= n), 32'd1);
  endtask

  task automatic cmp_frame(input int which, input int base, input int pat, input int cv, input string tag);
    beat_t b;
    int    n;
    n = (which == 0) ? q0.size() : q1.size();
    if (n < base + W * H) begin
      check_eq({tag, "_len"}, 32'(n), 32'(base + W * H));
      return;
    end
    for (int v = 0; v < H; v++) begin
      for (int h = 0; h < W; h++) begin
        b = (which == 0) ? q0[base + v * W + h] : q1[base + v * W + h];
        check_eq($sformatf("%s_pix%0d", tag, v * W + h), 32'(b.data), 32'(exp_pix(pat, cv, h, v)));
        check_eq($sformatf("%s_last%0d", tag, v * W + h), 32'(b.last), 32'(h == W - 1));
        check_eq($sformatf("%s_user%0d", tag, v * W + h), 32'(b.user), 32'(h == 0 && v == 0));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat, cv, v_snap;

    // Reset state
    tick(3);
    check_eq("rst_vld0", 32'(if0.tvalid), 0);
    check_eq("rst_dat0", 32'(if0.tdata), 0);
    check_eq("rst_last0", 32'(if0.tlast), 0);
    check_eq("rst_user0", 32'(if0.tuser), 0);
    check_eq("rst_busy0", 32'(busy0), 0);
    check_eq("rst_fd0", 32'(fd0), 0);
    check_eq("rst_vld1", 32'(if1.tvalid), 0);
    check_eq("rst_busy1", 32'(busy1), 0);
    rst_n = 1'b1;
    tick(2);

    // Single frame, pattern 0, full throughput; a second start while busy is ignored
    q0.delete(); fdq0.delete(); fdb0.delete();
    pattern_sel = 2'd0;
    pulse_start(0);
    tick(1);
    pulse_start(0);
    wait_idle(0, 100, "single");
    tick(4);
    check_eq("single_n", 32'(q0.size()), 32'(W * H));
    cmp_frame(0, 0, 0, 0, "single");
    if (q0.size() == W * H) begin
      for (int i = 1; i < W * H; i++)
        check_eq($sformatf("single_gap%0d", i), 32'(q0[i].cyc - q0[i - 1].cyc), 32'd1);
      check_eq("single_fd_n", 32'(fdq0.size()), 32'd1);
      if (fdq0.size() > 0) begin
        check_eq("single_fd_cyc", 32'(fdq0[0]), 32'(q0[W * H - 1].cyc + 1));
        check_eq("single_fd_busy", 32'(fdb0[0]), 32'd0);
      end
    end

    // Random backpressure, random patterns; inputs scrambled right after the latch
    rnd0 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      q0.delete();
      pat = (k < 4) ? k : int'($urandom_range(0, 3));
      cv  = int'($urandom_range(0, 255));
      pattern_sel = 2'(pat);
      const_value = DW'(cv);
      pulse_start(0);
      pattern_sel = 2'($urandom);
      const_value = DW'($urandom);
      wait_idle(0, 400, "rand");
      tick(2);
      check_eq("rand_n", 32'(q0.size()), 32'(W * H));
      cmp_frame(0, 0, pat, cv, "rand");
    end
    rnd0 = 1'b0;
    tick(2);

    // Gapped instance, continuous, stopped during frame 2
    q1.delete();
    continuous = 1'b1;
    pattern_sel = 2'd1;
    pulse_start(1);
    wait_beats(1, 10, 200, "gap");
    pulse_stop();
    wait_idle(1, 200, "gap");
    tick(3);
    check_eq("gap_n", 32'(q1.size()), 32'(2 * W * H));
    cmp_frame(1, 0, 1, 0, "gap_f1");
    cmp_frame(1, W * H, 1, 0, "gap_f2");
    if (q1.size() >= 2 * W * H) begin
      check_eq("gap_b01", 32'(q1[1].cyc - q1[0].cyc), 32'd1);
      check_eq("gap_line", 32'(q1[4].cyc - q1[3].cyc), 32'd3);
      check_eq("gap_frame", 32'(q1[8].cyc - q1[7].cyc), 32'd4);
      check_eq("gap_f2_user", 32'(q1[8].user), 32'd1);
    end

    // Continuous with stop at beat 5: frame completes, nothing after
    q0.delete();
    pattern_sel = 2'd0;
    pulse_start(0);
    wait_beats(0, 5, 100, "stop");
    pulse_stop();
    wait_idle(0, 100, "stop");
    v_snap = vld0;
    tick(20);
    check_eq("stop_n", 32'(q0.size()), 32'(W * H));
    check_eq("stop_quiet", 32'(vld0), 32'(v_snap));
    cmp_frame(0, 0, 0, 0, "stop");

    // Simultaneous start and stop in IDLE: exactly one frame
    q0.delete();
    @(posedge clk); #1;
    start0 = 1'b1; stop = 1'b1;
    tick(1);
    start0 = 1'b0; stop = 1'b0;
    wait_idle(0, 100, "ss");
    tick(10);
    check_eq("ss_n", 32'(q0.size()), 32'(W * H));
    continuous = 1'b0;

    // Constant pattern latched; const_value and pattern_sel changed mid-frame
    q0.delete();
    pattern_sel = 2'd3;
    const_value = 8'hA5;
    pulse_start(0);
    wait_beats(0, 3, 50, "const");
    const_value = 8'h00;
    pattern_sel = 2'd0;
    wait_idle(0, 100, "const");
    tick(2);
    cmp_frame(0, 0, 3, 8'hA5, "const");

    // Reset asserted while beat 2 is presented
    q0.delete();
    pattern_sel = 2'd0;
    pulse_start(0);
    wait_beats(0, 2, 50, "arst");
    check_eq("arst_vld_pre", 32'(if0.tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_vld", 32'(if0.tvalid), 32'd0);
    check_eq("arst_busy", 32'(busy0), 32'd0);
    check_eq("arst_dat", 32'(if0.tdata), 32'd0);
    check_eq("arst_user", 32'(if0.tuser), 32'd0);
    tick(2);
    rst_n = 1'b1;
    v_snap = vld0;
    tick(10);
    check_eq("arst_quiet", 32'(vld0), 32'(v_snap));
    q0.delete();
    pulse_start(0);
    wait_idle(0, 100, "arst2");
    tick(2);
    check_eq("arst2_n", 32'(q0.size()), 32'(W * H));
    cmp_frame(0, 0, 0, 0, "arst2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
